// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch-stage sequencer: FSM states, redirect priority codes
// and default vectors.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Numeric order is the arbitration order, so prio codes compare directly.
  typedef enum logic [1:0] {
    PRIO_NONE = 2'd0,
    PRIO_JMP  = 2'd1,
    PRIO_BR   = 2'd2,
    PRIO_TRAP = 2'd3
  } prio_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;
  localparam int          DEF_WDOG_W    = 8;

  function automatic logic [31:0] align4(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_arb.sv
// Next-PC source arbitration plus the pending-redirect register that holds a
// redirect across PC stalls. FETCH_CTRL_PERF_EN adds the 'applied' strobe.
module fetch_redirect_arb
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        stall,
  input  logic [31:0] pc,
  input  logic        trap,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output prio_t       in_prio,
  output logic [31:0] newpc
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic        applied
`endif
);

  logic [31:0] in_target;
  logic        pend_valid_reg;
  prio_t       pend_prio_reg;
  logic [31:0] pend_target_reg;

  always_comb begin
    in_prio   = PRIO_NONE;
    in_target = '0;
    if (en) begin
      if (trap) begin
        in_prio   = PRIO_TRAP;
        in_target = align4(TRAP_VEC);
      end else if (br_taken) begin
        in_prio   = PRIO_BR;
        in_target = align4(br_target);
      end else if (jmp) begin
        in_prio   = PRIO_JMP;
        in_target = align4(jmp_target);
      end
    end
  end

  // A live source always beats the held one once the PC is free to move.
  always_comb begin
    if (in_prio != PRIO_NONE)
      newpc = in_target;
    else if (pend_valid_reg)
      newpc = pend_target_reg;
    else
      newpc = pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_reg  <= 1'b0;
      pend_prio_reg   <= PRIO_NONE;
      pend_target_reg <= '0;
    end else if (en && !stall) begin
      pend_valid_reg  <= 1'b0;
      pend_prio_reg   <= PRIO_NONE;
    end else if (en && stall && in_prio != PRIO_NONE && in_prio >= pend_prio_reg) begin
      pend_valid_reg  <= 1'b1;
      pend_prio_reg   <= in_prio;
      pend_target_reg <= in_target;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  assign applied = en && !stall && ((in_prio != PRIO_NONE) || pend_valid_reg);
`endif

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer: IDLE/FETCH/WAIT/HALT FSM, imem watchdog and redirect
// arbitration. Define FETCH_CTRL_PERF_EN for stall/redirect performance counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] TRAP_VEC  = DEF_TRAP_VEC,
  parameter int          WDOG_W    = DEF_WDOG_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic        hazard_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        trap,
  input  logic        halt,
  output logic        pc_run,
  output logic        pc_stall,
  output logic [31:0] newpc,
  output logic        flush_if,
  output logic        flush_id,
  output logic        halted,
  output logic        imem_timeout
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_cnt
`endif
);

  localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_MAX - 1'b1;

  state_t            state_reg, state_next;
  logic [WDOG_W-1:0] wdog_reg, wdog_next;
  logic              timeout_reg, timeout_next;
  logic              pc_run_reg;
  logic              redir_en;
  prio_t             in_prio;
  logic [31:0]       arb_newpc;
`ifdef FETCH_CTRL_PERF_EN
  logic              redirect_applied;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      wdog_reg    <= '0;
      timeout_reg <= 1'b0;
      pc_run_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wdog_reg    <= wdog_next;
      timeout_reg <= timeout_next;
      pc_run_reg  <= (state_next != ST_IDLE);
    end
  end

  always_comb begin
    state_next   = state_reg;
    wdog_next    = wdog_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_FETCH;
      ST_FETCH: begin
        wdog_next = '0;
        if (!imem_ready)
          state_next = ST_WAIT;
        else if (halt && !pc_stall)
          state_next = ST_HALT;
      end
      ST_WAIT: begin
        if (imem_ready) begin
          state_next = ST_FETCH;
          wdog_next  = '0;
        end else if (wdog_reg == WDOG_LAST) begin
          // The watchdog reaches all-ones on the edge that gives up on imem.
          state_next   = ST_HALT;
          wdog_next    = WDOG_MAX;
          timeout_next = 1'b1;
        end else begin
          wdog_next = wdog_reg + 1'b1;
        end
      end
      default: state_next = ST_HALT;
    endcase
  end

  assign redir_en     = (state_reg == ST_FETCH) || (state_reg == ST_WAIT);
  assign imem_req     = redir_en;
  assign pc_stall     = hazard_stall || (state_reg != ST_FETCH) || !imem_ready;
  assign pc_run       = pc_run_reg;
  assign halted       = (state_reg == ST_HALT);
  assign imem_timeout = timeout_reg;
  assign flush_if     = (in_prio != PRIO_NONE);
  assign flush_id     = (in_prio >= PRIO_BR);

  always_comb begin
    case (state_reg)
      ST_IDLE: newpc = RESET_VEC;
      ST_HALT: newpc = pc;
      default: newpc = arb_newpc;
    endcase
  end

  fetch_redirect_arb #(
    .TRAP_VEC(TRAP_VEC)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (redir_en),
    .stall     (pc_stall),
    .pc        (pc),
    .trap      (trap),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jmp       (jmp),
    .jmp_target(jmp_target),
    .in_prio   (in_prio),
    .newpc     (arb_newpc)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .applied   (redirect_applied)
`endif
  );

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] redirect_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_reg <= '0;
      redirect_cnt_reg <= '0;
    end else begin
      if (pc_run_reg && pc_stall && stall_cycles_reg != '1)
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (redirect_applied && redirect_cnt_reg != '1)
        redirect_cnt_reg <= redirect_cnt_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign redirect_cnt = redirect_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl using immediate assertions.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, imem_ready, hazard_stall, br_taken, jmp, trap, halt;
  logic [31:0] pc, br_target, jmp_target;
  logic        imem_req, pc_run, pc_stall, flush_if, flush_id, halted, imem_timeout;
  logic [31:0] newpc;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_cycles, redirect_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .hazard_stall(hazard_stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .trap        (trap),
    .halt        (halt),
    .pc_run      (pc_run),
    .pc_stall    (pc_stall),
    .newpc       (newpc),
    .flush_if    (flush_if),
    .flush_id    (flush_id),
    .halted      (halted),
    .imem_timeout(imem_timeout)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .redirect_cnt(redirect_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; imem_ready = 1'b1; hazard_stall = 1'b0;
    br_taken = 1'b0; jmp = 1'b0; trap = 1'b0; halt = 1'b0;
    pc = 32'h0; br_target = 32'h0; jmp_target = 32'h0;

    // reset state
    repeat (3) step();
    chk("rst_pc_run",   {31'b0, pc_run},       32'd0);
    chk("rst_pc_stall", {31'b0, pc_stall},     32'd1);
    chk("rst_newpc",    newpc,                 32'h0);
    chk("rst_imem_req", {31'b0, imem_req},     32'd0);
    chk("rst_flush",    {30'b0, flush_if, flush_id}, 32'd0);
    chk("rst_halted",   {31'b0, halted},       32'd0);
    chk("rst_timeout",  {31'b0, imem_timeout}, 32'd0);

    // start, sequential fetch
    rst = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("start_pc_run", {31'b0, pc_run}, 32'd1);
    chk("start_req",    {31'b0, imem_req}, 32'd1);
    pc = 32'h0; #1;
    chk("seq_0",        newpc, 32'h4);
    chk("seq_stall",    {31'b0, pc_stall}, 32'd0);
    step(); pc = 32'h4; #1;
    chk("seq_4",        newpc, 32'h8);
    step(); pc = 32'hFFFF_FFFC; #1;
    chk("seq_wrap",     newpc, 32'h0);

    // jump during hazard stall is held until release
    step();
    pc = 32'h1000; hazard_stall = 1'b1; jmp = 1'b1; jmp_target = 32'h2000; #1;
    chk("jstall_fif",   {31'b0, flush_if}, 32'd1);
    chk("jstall_fid",   {31'b0, flush_id}, 32'd0);
    chk("jstall_stall", {31'b0, pc_stall}, 32'd1);
    step(); jmp = 1'b0; #1;
    chk("jstall_fif2",  {31'b0, flush_if}, 32'd0);
    step(); hazard_stall = 1'b0; #1;
    chk("jrel_newpc",   newpc, 32'h2000);
    step(); #1;
    chk("jafter_newpc", newpc, 32'h1004);

    // all three sources at once: trap wins
    trap = 1'b1; br_taken = 1'b1; br_target = 32'h3000; jmp = 1'b1; jmp_target = 32'h4000; #1;
    chk("all_newpc",    newpc, 32'h80);
    chk("all_fif",      {31'b0, flush_if}, 32'd1);
    chk("all_fid",      {31'b0, flush_id}, 32'd1);
    step(); trap = 1'b0; jmp = 1'b0; br_target = 32'h3003; #1;
    chk("br_align",     newpc, 32'h3000);
    chk("br_fid",       {31'b0, flush_id}, 32'd1);
    step(); br_taken = 1'b0;

    // pending jmp overwritten by higher-priority branch
    hazard_stall = 1'b1; jmp = 1'b1; jmp_target = 32'h4000;
    step(); jmp = 1'b0; br_taken = 1'b1; br_target = 32'h5000;
    step(); br_taken = 1'b0; hazard_stall = 1'b0; #1;
    chk("pend_up",      newpc, 32'h5000);
    step();

    // pending branch not overwritten by lower-priority jump
    hazard_stall = 1'b1; br_taken = 1'b1; br_target = 32'h6000;
    step(); br_taken = 1'b0; jmp = 1'b1; jmp_target = 32'h7000;
    step(); jmp = 1'b0; hazard_stall = 1'b0; #1;
    chk("pend_keep",    newpc, 32'h6000);
    step(); pc = 32'h6000; #1;
    chk("pend_clear",   newpc, 32'h6004);

    // imem watchdog
    imem_ready = 1'b0; #1;
    chk("wd_req",       {31'b0, imem_req}, 32'd1);
    chk("wd_stall",     {31'b0, pc_stall}, 32'd1);
    repeat (200) step();
    chk("wd_early",     {31'b0, halted}, 32'd0);
    repeat (60) step();
    chk("wd_halted",    {31'b0, halted}, 32'd1);
    chk("wd_timeout",   {31'b0, imem_timeout}, 32'd1);
    chk("wd_req_off",   {31'b0, imem_req}, 32'd0);
    rst = 1'b1; step(); rst = 1'b0; imem_ready = 1'b1; #1;
    chk("wd_rst_halt",  {31'b0, halted}, 32'd0);
    chk("wd_rst_to",    {31'b0, imem_timeout}, 32'd0);
    chk("wd_rst_run",   {31'b0, pc_run}, 32'd0);

    // halt: PC frozen and redirects ignored
    start = 1'b1; step(); start = 1'b0;
    halt = 1'b1; pc = 32'h100; #1;
    chk("halt_go",      {31'b0, pc_stall}, 32'd0);
    step(); halt = 1'b0; #1;
    chk("halt_state",   {31'b0, halted}, 32'd1);
    chk("halt_stall",   {31'b0, pc_stall}, 32'd1);
    chk("halt_req",     {31'b0, imem_req}, 32'd0);
    br_taken = 1'b1; br_target = 32'h5000; #1;
    chk("halt_nofif",   {31'b0, flush_if}, 32'd0);
    chk("halt_nofid",   {31'b0, flush_id}, 32'd0);
    step(); br_taken = 1'b0; #1;
    chk("halt_stays",   {31'b0, halted}, 32'd1);

    // reset mid-WAIT drops a pending redirect
    rst = 1'b1; step(); rst = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    imem_ready = 1'b0; jmp = 1'b1; jmp_target = 32'h8000; #1;
    chk("mw_fif",       {31'b0, flush_if}, 32'd1);
    step(); jmp = 1'b0; rst = 1'b1;
    step(); rst = 1'b0; #1;
    chk("mw_run",       {31'b0, pc_run}, 32'd0);
    chk("mw_req",       {31'b0, imem_req}, 32'd0);
    chk("mw_newpc",     newpc, 32'h0);
    start = 1'b1; step(); start = 1'b0; imem_ready = 1'b1; pc = 32'h200; #1;
    chk("mw_dropped",   newpc, 32'h204);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
